// File: rtl/shift_arbiter_pkg.sv
// Shared types and widths for shift_arbiter and other shared-datapath units.
// Widths follow BIN_LEN / DELTA_LEN / OUT_BIN_LEN; defaults apply when sys_defs.svh is not in the build.
`ifndef BIN_LEN
`define BIN_LEN 8
`endif
`ifndef DELTA_LEN
`define DELTA_LEN 5
`endif
`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 16
`endif

package shift_arbiter_pkg;

   localparam int unsigned BIN_W           = `BIN_LEN;
   localparam int unsigned DELTA_W         = `DELTA_LEN;
   localparam int unsigned OUT_W           = `OUT_BIN_LEN;
   localparam int unsigned NUM_REQ_DEFAULT = 4;
   localparam int unsigned MAX_ID_W        = 4;

   typedef struct packed {
      logic [BIN_W-1:0]   bin;
      logic [DELTA_W-1:0] delta;
   } shift_req_t;

   typedef struct packed {
      logic [OUT_W-1:0]    val;
      logic [MAX_ID_W-1:0] id;
      logic                ovf;
   } shift_res_t;

   // True when any set bit of the zero-extended operand lands above bit OUT_W-1.
   function automatic logic shift_ovf(input logic [BIN_W-1:0] bin,
                                      input logic [DELTA_W-1:0] delta);
      logic [OUT_W-1:0] ext;
      ext = OUT_W'(bin);
      if (32'(delta) >= OUT_W) return |bin;
      return |(ext >> (OUT_W - 32'(delta)));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past i_ptr and wraps; first requester wins.
// Reusable by any shared datapath unit.
module rr_arbiter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         i_en,
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_grant,
   output logic [W-1:0] o_winner
);

   logic         w_found;
   logic [W-1:0] w_idx;

   always_comb begin
      o_grant  = '0;
      o_winner = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_idx = W'((32'(i_ptr) + k) % N);
         if (i_en && !w_found && i_req[w_idx]) begin
            w_found         = 1'b1;
            o_grant[w_idx]  = 1'b1;
            o_winner        = w_idx;
         end
      end
   end

endmodule

// File: rtl/shifter.sv
// Shared left-shift datapath: o_result = zero-extend(i_bin) << i_delta, truncated.
// Output is meaningless while i_en is low and must not be loaded.
module shifter
   import shift_arbiter_pkg::*;
(
   input  logic               i_en,
   input  logic [BIN_W-1:0]   i_bin,
   input  logic [DELTA_W-1:0] i_delta,
   output logic [OUT_W-1:0]   o_result
);

   assign o_result = i_en ? (OUT_W'(i_bin) << i_delta) : '0;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one shifter among NUM_REQ requesters with a registered, tagged result.
// Optional SHIFT_ARB_OVF_EN adds the res_ovf output.
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0][BIN_W-1:0]     req_bin,
   input  logic [NUM_REQ-1:0][DELTA_W-1:0]   req_delta,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic [OUT_W-1:0]                  res_val,
   output logic [ID_W-1:0]                   res_id
`ifdef SHIFT_ARB_OVF_EN
   ,
   output logic                              res_ovf
`endif
);

   logic              r_res_valid;
   shift_res_t        r_res;
   logic [ID_W-1:0]   r_ptr;

   logic              w_free;
   logic              w_arb_en;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]   w_winner;
   logic              w_gnt;
   shift_req_t        w_req;
   logic [OUT_W-1:0]  w_shift_out;
   logic              w_ovf;
   logic              w_unused;

   assign w_free   = !r_res_valid || res_ready;
   assign w_arb_en = w_free && !reset;

   rr_arbiter #(
      .N (NUM_REQ),
      .W (ID_W)
   ) u_rr_arbiter (
      .i_en     (w_arb_en),
      .i_req    (req_valid),
      .i_ptr    (r_ptr),
      .o_grant  (w_grant),
      .o_winner (w_winner)
   );

   assign w_gnt     = |w_grant;
   assign req_ready = w_grant;

   always_comb begin
      w_req.bin   = req_bin[w_winner];
      w_req.delta = req_delta[w_winner];
   end

   shifter u_shifter (
      .i_en     (w_gnt),
      .i_bin    (w_req.bin),
      .i_delta  (w_req.delta),
      .o_result (w_shift_out)
   );

`ifdef SHIFT_ARB_OVF_EN
   assign w_ovf = shift_ovf(w_req.bin, w_req.delta);
`else
   assign w_ovf = 1'b0;
`endif

   // A grant loads over a result being consumed in the same cycle, so there is no bubble.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_res_valid <= 1'b0;
         r_res       <= '0;
         r_ptr       <= ID_W'(NUM_REQ - 1);
      end else if (w_gnt) begin
         r_res_valid <= 1'b1;
         r_res.val   <= w_shift_out;
         r_res.id    <= MAX_ID_W'(w_winner);
         r_res.ovf   <= w_ovf;
         r_ptr       <= w_winner;
      end else if (res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

   assign res_valid = r_res_valid;
   assign res_val   = r_res.val;
   assign res_id    = r_res.id[ID_W-1:0];
`ifdef SHIFT_ARB_OVF_EN
   assign res_ovf   = r_res.ovf;
`endif

   assign w_unused = ^{r_res.id, r_res.ovf};

endmodule
